// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes are row-major: code = row*4 + col.
package keypad_pkg;

  localparam int unsigned SETTLE_CYCLES  = 4;
  localparam int unsigned DEBOUNCE_SCANS = 8;
  localparam int unsigned N_ROWS         = 4;
  localparam int unsigned N_COLS         = 4;
  localparam int unsigned N_KEYS         = N_ROWS * N_COLS;
  localparam int unsigned SETTLE_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned CODE_W         = 4;

  localparam logic [CODE_W-1:0] KEY_CELL0   = 4'd0;
  localparam logic [CODE_W-1:0] KEY_CELL1   = 4'd1;
  localparam logic [CODE_W-1:0] KEY_CELL2   = 4'd2;
  localparam logic [CODE_W-1:0] KEY_CELL3   = 4'd3;
  localparam logic [CODE_W-1:0] KEY_CELL4   = 4'd4;
  localparam logic [CODE_W-1:0] KEY_CELL5   = 4'd5;
  localparam logic [CODE_W-1:0] KEY_CELL6   = 4'd6;
  localparam logic [CODE_W-1:0] KEY_CELL7   = 4'd7;
  localparam logic [CODE_W-1:0] KEY_CELL8   = 4'd8;
  localparam logic [CODE_W-1:0] KEY_RESTART = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_class_t;

  typedef struct packed {
    scan_class_t         cls;
    logic [CODE_W-1:0]   code;
  } scan_result_t;

  // Snapshot bit 4*col+row maps to code 4*row+col, so the code is the index with its halves swapped.
  function automatic scan_result_t classify(input logic [N_KEYS-1:0] snap);
    scan_result_t res;
    logic [4:0]   hits;
    logic [3:0]   bit_idx;
    hits = '0;
    res  = '{cls: SCAN_NONE, code: 4'd0};
    for (int b = 0; b < N_KEYS; b++) begin
      bit_idx = 4'(b);
      if (snap[b]) begin
        res.code = {bit_idx[1:0], bit_idx[3:2]};
        hits     = hits + 5'd1;
      end
    end
    if (hits == 5'd0)      res.cls = SCAN_NONE;
    else if (hits == 5'd1) res.cls = SCAN_SINGLE;
    else                   res.cls = SCAN_MULTI;
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Double-flop synchronizer for the asynchronous keypad row inputs.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, row snapshot, debounce FSM.
// Emits one key code pulse per accepted press; multi-key scans never create or end a press.
module keypad_scanner
  import keypad_pkg::*;
(
  input  logic                clk_10000Hz,
  input  logic                reset,
  input  logic [N_ROWS-1:0]   key_row,
  output logic [N_COLS-1:0]   key_col,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held
);

  logic [N_ROWS-1:0]   w_row_sync;
  logic                w_last_settle;

  logic [SETTLE_W-1:0] r_settle;
  logic [1:0]          r_col_idx;
  logic [N_COLS-1:0]   r_key_col;
  logic [N_KEYS-1:0]   r_snap;
  logic                r_scan_done;
  logic                r_res_vld;
  scan_result_t        r_res;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CODE_W-1:0]   r_cand;
  logic [CODE_W-1:0]   r_key_code;
  logic                r_key_valid;
  logic                r_key_held;

  sync2 #(.WIDTH(N_ROWS)) u_sync (
    .clk   (clk_10000Hz),
    .rst_n (reset),
    .i_d   (key_row),
    .o_q   (w_row_sync)
  );

  assign w_last_settle = (r_settle == SETTLE_W'(SETTLE_CYCLES - 1));

  // Free-running column scan; rows of column j land in snapshot bits [4j+3:4j].
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      r_settle    <= '0;
      r_col_idx   <= '0;
      r_key_col   <= 4'b1110;
      r_snap      <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= w_last_settle && (r_col_idx == 2'd3);
      if (w_last_settle) begin
        r_settle                       <= '0;
        r_col_idx                      <= r_col_idx + 2'd1;
        r_key_col                      <= {r_key_col[2:0], r_key_col[3]};
        r_snap[{r_col_idx, 2'b00} +: 4] <= ~w_row_sync;
      end else begin
        r_settle <= r_settle + SETTLE_W'(1);
      end
    end
  end

  // Classification is registered once per scan to keep the popcount off the FSM path.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      r_res_vld <= 1'b0;
      r_res     <= '0;
    end else begin
      r_res_vld <= r_scan_done;
      if (r_scan_done) r_res <= classify(r_snap);
    end
  end

  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_res_vld) begin
        case (r_state)
          IDLE: begin
            if (r_res.cls == SCAN_SINGLE) begin
              r_cand  <= r_res.code;
              r_cnt   <= CNT_W'(1);
              r_state <= CONFIRM;
            end
          end
          CONFIRM: begin
            if ((r_res.cls == SCAN_SINGLE) && (r_res.code == r_cand)) begin
              if (r_cnt >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
                r_cnt       <= CNT_W'(DEBOUNCE_SCANS);
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_state     <= HELD;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end
          HELD: begin
            if (r_res.cls == SCAN_NONE) begin
              r_cnt   <= CNT_W'(1);
              r_state <= RELEASE;
            end
          end
          RELEASE: begin
            if (r_res.cls == SCAN_NONE) begin
              if (r_cnt >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
                r_cnt      <= CNT_W'(DEBOUNCE_SCANS);
                r_key_held <= 1'b0;
                r_state    <= IDLE;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= HELD;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign key_col   = r_key_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural 4x4 matrix closes rows onto driven columns.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] press = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int pulses = 0;
  int pulse_lat = 0;
  int pulse_code = 0;
  logic prev_valid = 1'b0;

  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K6 = 16'h0040;
  localparam logic [15:0] K9 = 16'h0200;

  keypad_scanner dut (
    .clk_10000Hz (clk),
    .reset       (rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      check("valid_not_back_to_back", int'(prev_valid), 0);
      pulses++;
      pulse_code = int'(key_code);
      pulse_lat  = cyc - rel_cyc;
    end
    prev_valid = key_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  // Returns just after the posedge that starts a new scan (column 0 driven again).
  task automatic align_scan();
    int n;
    n = 0;
    while (key_col != 4'b0111 && n < 40) begin step(1); n++; end
    while (key_col != 4'b1110 && n < 40) begin step(1); n++; end
    check("align_scan_in_budget", int'(n < 40), 1);
  endtask

  task automatic wait_held_fall(output int n);
    n = 0;
    while (key_held && n < 400) begin step(1); n++; end
    if (key_held) n = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_col"},   int'(key_col),   14);
    check({tag, "_key_code"},  int'(key_code),  0);
    check({tag, "_key_valid"}, int'(key_valid), 0);
    check({tag, "_key_held"},  int'(key_held),  0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    logic [3:0] exp_col;
    logic [3:0] codes [3];
    codes = '{KEY_RESTART, KEY_CELL0, 4'd12};

    step(3);
    check_reset_outputs("rst");
    release_reset();

    // Free-running scan with no key pressed
    for (int k = 0; k < 32; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("col_scan", int'(key_col), int'(exp_col));
      step(1);
    end
    step(2000 - 32);
    check("idle_no_valid", pulses, 0);

    // Steady press of code 6 from reset release
    rst_n = 1'b0;
    press = K6;
    step(2);
    release_reset();
    p0 = pulses;
    step(200);
    check("t2_pulses", pulses - p0, 1);
    check("t2_code", pulse_code, 6);
    check("t2_latency_130_146", int'(pulse_lat >= 130 && pulse_lat <= 146), 1);
    check("t2_held", int'(key_held), 1);

    // Release aligned to a scan start, then press/release/re-press
    align_scan();
    press = '0;
    wait_held_fall(n);
    check("t5_release_latency", int'(n >= 128 && n <= 146), 1);
    p0 = pulses;
    press = K6;
    step(200);
    check("t5_new_press_pulse", pulses - p0, 1);
    press = '0;
    step(60);
    press = K6;
    step(400);
    check("t5_repress_no_pulse", pulses - p0, 1);
    check("t5_repress_still_held", int'(key_held), 1);
    press = '0;
    wait_held_fall(n);
    check("t5_final_release", int'(n > 0), 1);

    // Bounce: toggle every 10 clk for 100 clk, then stable
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      press = (i % 2 == 0) ? K6 : 16'h0000;
      step(10);
    end
    check("t3_bounce_quiet", pulses - p0, 0);
    press = K6;
    step(200);
    check("t3_single_pulse", pulses - p0, 1);
    check("t3_code", pulse_code, 6);
    press = '0;
    wait_held_fall(n);
    check("t3_release", int'(n > 0), 1);

    // Ghost pair 5+9 rejected; 5 alone accepted; extra key while held ignored
    p0 = pulses;
    press = K5 | K9;
    step(400);
    check("t4_multi_quiet", pulses - p0, 0);
    press = K5;
    step(200);
    check("t4_single_pulse", pulses - p0, 1);
    check("t4_code", pulse_code, 5);
    press = K5 | K9;
    step(300);
    check("t4_second_key_ignored", pulses - p0, 1);
    check("t4_still_held", int'(key_held), 1);
    press = '0;
    wait_held_fall(n);
    check("t4_release", int'(n > 0), 1);

    // Corner codes of the matrix
    for (int i = 0; i < 3; i++) begin
      p0 = pulses;
      press = 16'(1) << codes[i];
      step(200);
      check("corner_pulse", pulses - p0, 1);
      check("corner_code", pulse_code, int'(codes[i]));
      press = '0;
      wait_held_fall(n);
      check("corner_release", int'(n > 0), 1);
    end

    // Reset 100 clk into a confirmation, then full re-confirmation
    align_scan();
    p0 = pulses;
    press = K6;
    step(100);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_in_reset");
    step(3);
    check("t6_no_pulse", pulses - p0, 0);
    release_reset();
    step(200);
    check("t6_pulse_after_reset", pulses - p0, 1);
    check("t6_code", pulse_code, 6);
    check("t6_latency_130_146", int'(pulse_lat >= 130 && pulse_lat <= 146), 1);
    press = '0;
    wait_held_fall(n);
    check("t6_release", int'(n > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
